// File: rtl/key_scheduler.sv
// -----------------------------------------------------------------------------
// key_scheduler
//
// Four push-button inputs are synchronised and debounced. Each accepted press
// becomes a single command (key index + short/long flag) offered on a
// valid/ready interface. Only one press is tracked at a time. Presses that
// arrive while a command is being built, offered or waiting for release are
// dropped rather than queued.
//
// Parameters
//   DEB_CNT   consecutive clean samples needed to accept a level change (>=2)
//   LONG_CNT  debounced hold cycles that turn a press into a long press
//             (>=2, greater than DEB_CNT)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   key        raw asynchronous button levels, 1 = pressed
//   key_state  debounced button levels
//   cmd_valid  a command is on offer
//   cmd_ready  consumer accepts the command on a rising edge with cmd_valid
//   cmd_key    index of the key in the current command
//   cmd_long   1 = long press, 0 = short press
//   busy       scheduler is not idle
// -----------------------------------------------------------------------------
module key_scheduler #(
    parameter int DEB_CNT  = 4,
    parameter int LONG_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [3:0] key_state,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_key,
    output logic       cmd_long,
    output logic       busy
);

    localparam int DEB_W  = (DEB_CNT  > 1) ? $clog2(DEB_CNT)  : 1;
    localparam int HOLD_W = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        EMIT,
        WAIT_REL
    } state_e;

    // Input side: synchroniser, debouncers, press arming
    logic [3:0]             sync1_q;
    logic [3:0]             sync2_q;
    logic [3:0]             key_state_q;
    logic [3:0]             key_state_d;
    logic [3:0][DEB_W-1:0]  deb_cnt_q;
    logic [3:0][DEB_W-1:0]  deb_cnt_d;
    logic [1:0]             prime_q;
    logic [3:0]             arm_q;
    logic [3:0]             arm_d;
    logic [3:0]             press_evt;

    // Command side: FSM, hold counter, command registers
    state_e                 state_q;
    state_e                 state_d;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [HOLD_W-1:0]      hold_cnt_d;
    logic [1:0]             cmd_key_q;
    logic [1:0]             cmd_key_d;
    logic                   cmd_long_q;
    logic                   cmd_long_d;
    logic [1:0]             grant_idx;
    logic                   granted_level;

    // prime_q fills with ones two edges after reset, which is when sync2_q
    // first carries a real sample of the pins. A key only becomes eligible
    // to generate presses (arm_q) once it has been seen released after that
    // point, so a button held through reset cannot fire a command until it
    // is let go and pressed again.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        key_state_d = key_state_q;
        deb_cnt_d   = deb_cnt_q;
        arm_d       = arm_q;
        press_evt   = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == key_state_q[i]) begin
                // Level agrees with the accepted state: any partial run of
                // disagreeing samples was a glitch, so start over.
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                key_state_d[i] = sync2_q[i];
                deb_cnt_d[i]   = '0;
                press_evt[i]   = sync2_q[i] & arm_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
            if (prime_q[1] && !sync2_q[i] && !key_state_q[i]) begin
                arm_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state is reset, debounce counters included, so a key held through reset is re-debounced from zero.
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            key_state_q <= '0;
            deb_cnt_q   <= '0;
            prime_q     <= '0;
            arm_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the values from before this edge.
            sync1_q     <= key;
            sync2_q     <= sync1_q;
            key_state_q <= key_state_d;
            deb_cnt_q   <= deb_cnt_d;
            prime_q     <= {prime_q[0], 1'b1};
            arm_q       <= arm_d;
        end
    end

    // Lowest-numbered key wins when several presses land in the same cycle.
    always_comb begin
        grant_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press_evt[i]) begin
                grant_idx = 2'(i);
            end
        end
    end

    // cmd_key_q doubles as the latched index of the key being tracked.
    assign granted_level = key_state_q[cmd_key_q];

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cmd_key_d  = cmd_key_q;
        cmd_long_d = cmd_long_q;
        unique case (state_q)
            IDLE: begin
                if (|press_evt) begin
                    cmd_key_d  = grant_idx;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (!granted_level) begin
                    cmd_long_d = 1'b0;
                    state_d    = EMIT;
                end else begin
                    // Decide on the incremented value so the long command is
                    // offered exactly LONG_CNT-1 cycles after the press.
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_d == LONG_LAST) begin
                        cmd_long_d = 1'b1;
                        state_d    = EMIT;
                    end
                end
            end
            EMIT: begin
                if (cmd_ready) begin
                    state_d = (cmd_long_q && granted_level) ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (!granted_level) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            cmd_key_q  <= '0;
            cmd_long_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cmd_key_q  <= cmd_key_d;
            cmd_long_q <= cmd_long_d;
        end
    end

    // Decoded straight from the state register, so reset removes the offer
    // immediately without waiting for a clock.
    assign cmd_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign key_state = key_state_q;
    assign cmd_key   = cmd_key_q;
    assign cmd_long  = cmd_long_q;

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001: Parameter DEB_CNT, default 4; consecutive clean samples required to accept a key level change (>=2).
REQ-002: Parameter LONG_CNT, default 16; debounced hold cycles that make a press "long" (>=2, must exceed DEB_CNT).
REQ-003: clk  input  1  single system clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous active-low reset.
REQ-005: key  input  4  raw asynchronous push-button levels, 1 = pressed.
REQ-006: key_state  output  4  debounced key levels.
REQ-007: cmd_valid  output  1  command available.
REQ-008: cmd_ready  input  1  consumer accepts command.
REQ-009: cmd_key  output  2  index of key in current command.
REQ-010: cmd_long  output  1  1 = long press, 0 = short press.
REQ-011: busy  output  1  high in any FSM state other than IDLE.

Function
REQ-012: Each key bit SHALL pass through a 2-flop synchronizer; sync output s[i] feeds its own debouncer.
REQ-013: Per-key debouncer: counter cleared whenever s[i]==key_state[i]; incremented while s[i]!=key_state[i]; when counter==DEB_CNT-1 with s[i]!=key_state[i], key_state[i]<=s[i] and counter<=0.
REQ-014: Any glitch returning s[i] to key_state[i] before acceptance SHALL clear that counter; no key_state change.
REQ-015: A press event for key i SHALL be the cycle key_state[i] goes 0->1; release = 1->0.
REQ-016: FSM states: IDLE, HOLD, EMIT, WAIT_REL.
REQ-017: IDLE: on press events, grant the lowest index among keys with a press event this cycle; latch index, clear hold counter, next HOLD.
REQ-018: Press events arriving in any state other than IDLE, and non-granted simultaneous presses, SHALL be discarded (no queueing).
REQ-019: HOLD: hold counter increments each cycle granted key_state stays 1; on release with counter < LONG_CNT-1 -> cmd_long<=0, next EMIT.
REQ-020: HOLD: when counter reaches LONG_CNT-1 while still pressed -> cmd_long<=1, next EMIT (long reported without waiting for release).
REQ-021: EMIT: cmd_valid=1, cmd_key/cmd_long stable until handshake; transfer when cmd_valid & cmd_ready on a rising edge.
REQ-022: After transfer: short -> IDLE; long -> WAIT_REL if key still pressed, else IDLE.
REQ-023: WAIT_REL: stay until granted key_state returns 0, then IDLE; no command emitted for the release.
REQ-024: cmd_valid SHALL never drop without a handshake; cmd_ready while cmd_valid=0 SHALL have no effect.
REQ-025: Hold counter width SHALL hold LONG_CNT-1 without wrap; saturation not needed since HOLD exits at that value.

Reset
REQ-026: rst low SHALL immediately force: synchronizers 0, debounce counters 0, key_state 0, FSM IDLE, cmd_valid 0, cmd_key 0, cmd_long 0, busy 0.
REQ-027: Reset asserted mid-operation (including EMIT) SHALL abort the command; no command is emitted after release for a key held through reset until it is released and re-pressed (debouncer re-accepts from 0).

Verification
REQ-028: key[0] toggles every 5 ns for 40 ns, 100 ns clock -> key_state stays 0, cmd_valid never 1.
REQ-029: key[1] held high 10 cycles then low, cmd_ready=1 -> key_state[1] rises 2+DEB_CNT cycles after edge; one command cmd_key=1, cmd_long=0.
REQ-030: key[2] held 40 cycles, cmd_ready=1 -> cmd_long=1 issued LONG_CNT-1 cycles after key_state[2] rise; busy stays 1 until release accepted; exactly one command.
REQ-031: key[0] and key[3] pressed same cycle -> one command cmd_key=0; key[3] discarded.
REQ-032: short press on key[1] with cmd_ready=0 for 20 cycles -> cmd_valid and cmd_key=1 held constant; single transfer when cmd_ready rises; new key[2] press during stall ignored.
REQ-033: rst pulsed low during EMIT -> cmd_valid drops asynchronously; after reset release no command until a fresh press.
